div_arbiter: RTL
================

DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter W, default 8: operand and result width, in bits.
REQ-002 Parameter TMO, default 64: maximum WAIT cycles allowed before a timeout abort.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req0, req1  input  1 each  requester level requests; held high until the matching ack.
REQ-006 a0, b0, a1, b1  input  W each  dividend/divisor per requester; stable while that req is high.
REQ-007 ack0, ack1  output  1 each  one-cycle completion pulse to requester 0 or 1.
REQ-008 q_out, r_out  output  W each  quotient/remainder; valid only while an ack is high.
REQ-009 err_out  output  1  result invalid (overflow, divide-by-zero or timeout); valid with ack.
REQ-010 tmo_out  output  1  response caused by a timeout; valid with ack.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 div_start  output  1  start pulse to the shared divider.
REQ-013 div_a, div_b  output  W each  dividend/divisor to the divider, from the latched operands.
REQ-014 div_done  input  1  divider completion (one-cycle pulse).
REQ-015 div_q, div_r  input  W each  divider quotient/remainder; sampled in the div_done cycle.
REQ-016 div_err  input  1  divider overflow or divide-by-zero flag; sampled with div_done.

Function
REQ-017 The FSM SHALL have the states IDLE, START, WAIT and RESP; state and outputs SHALL be registered.
REQ-018 IDLE: with no req, remain in IDLE; otherwise grant one requester, latch its a/b into div_a/div_b, record the owner, and go to START.
REQ-019 Arbitration SHALL be round-robin with pointer prio: when both reqs are high, grant requester prio; when only one is high, grant that one.
REQ-020 After each RESP, prio SHALL become the index of the requester not served.
REQ-021 START: div_start=1 for exactly this one cycle, WAIT counter cleared, then go to WAIT.
REQ-022 WAIT with div_done=1: latch div_q, div_r and div_err into q_out, r_out and err_out; set tmo_out=0; go to RESP.
REQ-023 WAIT with div_done=0: increment the counter; at the TMO-th WAIT cycle without div_done, set q_out=0, r_out=0, err_out=1, tmo_out=1 and go to RESP.
REQ-024 The WAIT counter SHALL be wide enough to hold TMO without wrap.
REQ-025 RESP: ack of the owner =1 for one cycle, the other ack =0; then go to IDLE.
REQ-026 RESP SHALL also serve as the divider's recovery cycle: div_start SHALL never be asserted within 2 cycles after div_done.
REQ-027 Latency: req high in IDLE -> div_start on the next cycle; div_done -> ack on the next cycle.
REQ-028 Minimum req-to-ack time SHALL be 3 cycles (IDLE, START, WAIT with immediate div_done).
REQ-029 req is sampled only in IDLE. A req still high in the cycle after its ack SHALL be treated as a new request.
REQ-030 Changes on req or operands outside IDLE SHALL have no effect on the operation in progress.
REQ-031 div_done outside WAIT SHALL be ignored.
REQ-032 div_a and div_b SHALL remain constant from START through RESP.
REQ-033 q_out, r_out, err_out and tmo_out SHALL hold their last value between responses.

Reset
REQ-034 rst=1 at a clock edge SHALL force: state IDLE, prio=0, counter=0, and all outputs 0 (ack0, ack1, div_start, busy, q_out, r_out, err_out, tmo_out, div_a, div_b).
REQ-035 Reset in any state, including WAIT, SHALL abandon the operation with no ack; a later div_done SHALL be ignored.

Verification
REQ-036 req0 with a0=100, b0=7; model returns q=14, r=2 -> div_start one cycle after req0, div_a=100, div_b=7; ack0 one cycle after div_done with q_out=14, r_out=2, err_out=0; ack1 never.
REQ-037 req0 and req1 high together after reset, held -> requester 0 served first, then requester 1, then 0 again; no cycle has two acks.
REQ-038 req1 with b1=0; model asserts div_err with div_done -> ack1 with err_out=1, tmo_out=0.
REQ-039 req0; model never asserts div_done -> ack0 exactly TMO WAIT cycles after START, with err_out=1, tmo_out=1, q_out=0, r_out=0.
REQ-040 rst pulsed during WAIT, then div_done pulsed -> all outputs 0, state IDLE, no ack.
REQ-041 div_done pulsed while IDLE, and req toggled during WAIT -> no state change from div_done; result and owner unchanged by the req toggling.

Source files
------------

// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a shared multi-cycle divider,
// with a WAIT-state timeout that aborts a stalled divide with an error response.
module div_arbiter #(
    parameter int W   = 8,
    parameter int TMO = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic         req1,
    input  logic [W-1:0] a0,
    input  logic [W-1:0] b0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] b1,
    output logic         ack0,
    output logic         ack1,
    output logic [W-1:0] q_out,
    output logic [W-1:0] r_out,
    output logic         err_out,
    output logic         tmo_out,
    output logic         busy,
    output logic         div_start,
    output logic [W-1:0] div_a,
    output logic [W-1:0] div_b,
    input  logic         div_done,
    input  logic [W-1:0] div_q,
    input  logic [W-1:0] div_r,
    input  logic         div_err
);

    localparam int CW = $clog2(TMO + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          prio_q, prio_d;
    logic          owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [W-1:0]  q_q, q_d;
    logic [W-1:0]  r_q, r_d;
    logic          err_q, err_d;
    logic          tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          start_q, start_d;
    logic [W-1:0]  da_q, da_d;
    logic [W-1:0]  db_q, db_d;
    logic          grant;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        q_d     = q_q;
        r_d     = r_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        busy_d  = busy_q;
        start_d = 1'b0;
        da_d    = da_q;
        db_d    = db_q;
        // Both requesting: pointer decides; otherwise the lone requester wins.
        grant   = (req0 && req1) ? prio_q : req1;

        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant;
                    da_d    = grant ? a1 : a0;
                    db_d    = grant ? b1 : b0;
                    start_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (div_done) begin
                    q_d     = div_q;
                    r_d     = div_r;
                    err_d   = div_err;
                    tmo_d   = 1'b0;
                    ack0_d  = ~owner_q;
                    ack1_d  = owner_q;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == CW'(TMO)) begin
                        q_d     = '0;
                        r_d     = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b1;
                        ack0_d  = ~owner_q;
                        ack1_d  = owner_q;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                prio_d  = ~owner_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            cnt_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            da_q    <= '0;
            db_q    <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            q_q     <= q_d;
            r_q     <= r_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            start_q <= start_d;
            da_q    <= da_d;
            db_q    <= db_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign q_out     = q_q;
    assign r_out     = r_q;
    assign err_out   = err_q;
    assign tmo_out   = tmo_q;
    assign busy      = busy_q;
    assign div_start = start_q;
    assign div_a     = da_q;
    assign div_b     = db_q;

endmodule
